// File: rtl/io_ram_arbiter.sv
// io_ram_arbiter
// Round-robin burst arbiter that shares one single-port IO RAM between the
// DMA write path and the compute-side read path. A grant lasts for a whole
// burst. When the other side is waiting, a burst is cut after maxBurst beats.
// Every hand-off passes through one IDLE cycle.
module io_ram_arbiter #(
   parameter int blockSize = 16,
   parameter int addrWidth = 16,
   parameter int maxBurst  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_req,
   input  logic [addrWidth-1:0] wr_address,
   input  logic [blockSize-1:0] wr_data,
   input  logic                 wr_last,
   output logic                 wr_grant,
   input  logic                 rd_req,
   input  logic [addrWidth-1:0] rd_address,
   input  logic                 rd_last,
   output logic                 rd_grant,
   output logic [blockSize-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 ram_enable,
   output logic                 ram_write,
   output logic [addrWidth-1:0] ram_address,
   output logic [blockSize-1:0] ram_input_data,
   input  logic [blockSize-1:0] ram_output_data
);

   localparam int CntW = $clog2(maxBurst + 1);
   localparam logic [CntW-1:0] CNT_LAST = CntW'(maxBurst - 1);
   localparam logic [CntW-1:0] CNT_MAX  = CntW'(maxBurst);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_served_q, last_served_d;   // 1: read was served last
   logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
   logic            rd_pending_q, rd_pending_d;

   // Request, last and competing request of the side that owns the current burst
   logic act_req_s, act_last_s, oth_req_s;

   // Select the owner's handshake signals from the current state
   always_comb begin
      act_req_s  = 1'b0;
      act_last_s = 1'b0;
      oth_req_s  = 1'b0;
      case (state_q)
         S_WR: begin
            act_req_s  = wr_req;
            act_last_s = wr_last;
            oth_req_s  = rd_req;
         end
         S_RD: begin
            act_req_s  = rd_req;
            act_last_s = rd_last;
            oth_req_s  = wr_req;
         end
         default: begin
            act_req_s  = 1'b0;
            act_last_s = 1'b0;
            oth_req_s  = 1'b0;
         end
      endcase
   end

   // Next-state logic: round-robin grant from IDLE, burst release conditions
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      beat_cnt_d    = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            beat_cnt_d = {CntW{1'b0}};
            if (wr_req && rd_req) begin
               if (last_served_q) begin
                  state_d       = S_WR;
                  last_served_d = 1'b0;
               end else begin
                  state_d       = S_RD;
                  last_served_d = 1'b1;
               end
            end else if (wr_req) begin
               state_d       = S_WR;
               last_served_d = 1'b0;
            end else if (rd_req) begin
               state_d       = S_RD;
               last_served_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR, S_RD: begin
            // Count beats, saturating so a long uncontested burst never wraps
            if (act_req_s && (beat_cnt_q != CNT_MAX)) begin
               beat_cnt_d = beat_cnt_q + CntW'(1);
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
            // A dropped request releases the RAM just like a last beat
            if (!act_req_s) begin
               state_d = S_IDLE;
            end else if (act_last_s) begin
               state_d = S_IDLE;
            end else if ((beat_cnt_q == CNT_LAST) && oth_req_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d    = S_IDLE;
            beat_cnt_d = {CntW{1'b0}};
         end
      endcase
   end

   // A read beat this cycle means RAM data comes back next cycle
   always_comb begin
      rd_pending_d = (state_q == S_RD) && rd_req;
   end

   // State and bookkeeping registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         last_served_q <= 1'b1;
         beat_cnt_q    <= {CntW{1'b0}};
         rd_pending_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         beat_cnt_q    <= beat_cnt_d;
         rd_pending_q  <= rd_pending_d;
      end
   end

   // RAM pin mux: driven only by the granted requester, all zero in IDLE
   always_comb begin
      wr_grant       = 1'b0;
      rd_grant       = 1'b0;
      ram_enable     = 1'b0;
      ram_write      = 1'b0;
      ram_address    = {addrWidth{1'b0}};
      ram_input_data = {blockSize{1'b0}};
      case (state_q)
         S_WR: begin
            wr_grant       = 1'b1;
            ram_enable     = wr_req;
            ram_write      = 1'b1;
            ram_address    = wr_address;
            ram_input_data = wr_data;
         end
         S_RD: begin
            rd_grant    = 1'b1;
            ram_enable  = rd_req;
            ram_write   = 1'b0;
            ram_address = rd_address;
         end
         default: begin
            wr_grant = 1'b0;
            rd_grant = 1'b0;
         end
      endcase
   end

   // Read return: RAM output is valid the cycle after a read beat
   always_comb begin
      rd_valid = rd_pending_q;
      if (rd_pending_q) begin
         rd_data = ram_output_data;
      end else begin
         rd_data = {blockSize{1'b0}};
      end
   end

endmodule

// File: tb/tb_io_ram_arbiter.sv
// Directed bench for io_ram_arbiter with a small synchronous RAM model.
// The arbiter is built with maxBurst = 4 so that forced release is easy to reach.
module tb_io_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req, wr_last, rd_req, rd_last;
   logic [15:0] wr_address, wr_data, rd_address;
   logic        wr_grant, rd_grant, rd_valid;
   logic        ram_enable, ram_write;
   logic [15:0] rd_data, ram_address, ram_input_data, ram_output_data;

   logic [15:0] mem [0:255];
   logic [15:0] pre [0:2];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   io_ram_arbiter #(.blockSize(16), .addrWidth(16), .maxBurst(4)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data), .wr_last(wr_last),
      .wr_grant(wr_grant),
      .rd_req(rd_req), .rd_address(rd_address), .rd_last(rd_last),
      .rd_grant(rd_grant), .rd_data(rd_data), .rd_valid(rd_valid),
      .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
      .ram_input_data(ram_input_data), .ram_output_data(ram_output_data)
   );

   // Synchronous single-port RAM model: read data appears one cycle after access
   always @(posedge clk) begin
      if (ram_enable && ram_write) mem[ram_address[7:0]] <= ram_input_data;
      if (ram_enable && !ram_write) ram_output_data <= mem[ram_address[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Move to the start of the next cycle; inputs are driven here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      pre[0] = 16'h5A01; pre[1] = 16'h5A02; pre[2] = 16'h5A03;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[16] = pre[0]; mem[17] = pre[1]; mem[18] = pre[2];
      ram_output_data = 16'h0000;
      rst = 1'b1;
      wr_req = 1'b0; wr_last = 1'b0; wr_address = 16'h0; wr_data = 16'h0;
      rd_req = 1'b0; rd_last = 1'b0; rd_address = 16'h0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_wr_grant", {31'd0, wr_grant}, 32'd0);
      chk("rst_rd_grant", {31'd0, rd_grant}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_enable}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_ram_addr", {16'd0, ram_address}, 32'd0);

      // Tie right after reset: write wins, read follows two cycles after the last write beat
      tick();
      wr_req = 1'b1; rd_req = 1'b1; wr_address = 16'h0020; wr_data = 16'hC000; rd_address = 16'h0010;
      #1;
      chk("tie1_idle", {30'd0, wr_grant, rd_grant}, 32'd0);
      tick(); #1;
      chk("tie1_wr_first", {30'd0, wr_grant, rd_grant}, 32'd2);
      tick(); wr_address = 16'h0021; wr_last = 1'b1; #1;
      chk("tie1_wr_beat2", {30'd0, wr_grant, ram_enable}, 32'd3);
      tick(); wr_req = 1'b0; wr_last = 1'b0; #1;
      chk("tie1_bubble", {29'd0, wr_grant, rd_grant, ram_enable}, 32'd0);
      tick(); rd_last = 1'b1; #1;
      chk("tie1_rd_grant", {30'd0, wr_grant, rd_grant}, 32'd1);
      chk("tie1_rd_addr", {16'd0, ram_address}, 32'h0010);
      tick(); rd_req = 1'b0; rd_last = 1'b0; #1;
      chk("tie1_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("tie1_rd_data", {16'd0, rd_data}, {16'd0, pre[0]});

      // Lone write of four beats
      tick(); wr_req = 1'b1; wr_address = 16'h0000; wr_data = 16'hA000; #1;
      chk("lw_no_grant_yet", {31'd0, wr_grant}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         wr_address = 16'(i); wr_data = 16'hA000 + 16'(i); wr_last = (i == 3);
         #1;
         chk("lw_grant_en_wr", {29'd0, wr_grant, ram_enable, ram_write}, 32'd7);
         chk("lw_addr", {16'd0, ram_address}, i);
         chk("lw_data", {16'd0, ram_input_data}, 32'hA000 + i);
      end
      // Release cycle doubles as the second tie: read was not served last now
      tick();
      wr_last = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
      wr_address = 16'h0030; wr_data = 16'hB000; rd_address = 16'h0011;
      #1;
      chk("lw_idle_after", {29'd0, wr_grant, rd_grant, ram_enable}, 32'd0);
      chk("lw_idle_data", {16'd0, ram_input_data}, 32'd0);
      chk("lw_mem3", {16'd0, mem[3]}, 32'hA003);
      tick(); rd_last = 1'b1; #1;
      chk("tie2_rd_wins", {30'd0, wr_grant, rd_grant}, 32'd1);
      chk("tie2_rd_data0", {16'd0, ram_input_data}, 32'd0);
      tick(); rd_req = 1'b0; rd_last = 1'b0; #1;
      chk("tie2_bubble", {30'd0, wr_grant, rd_grant}, 32'd0);
      chk("tie2_rd_data", {16'd0, rd_data}, {16'd0, pre[1]});
      tick(); wr_last = 1'b1; #1;
      chk("tie2_wr_next", {30'd0, wr_grant, ram_enable}, 32'd3);
      tick(); wr_req = 1'b0; wr_last = 1'b0; #1;
      chk("tie2_done", {31'd0, wr_grant}, 32'd0);

      // Lone read of three preloaded words
      rd_req = 1'b1; rd_address = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         tick();
         rd_address = 16'h0010 + 16'(i); rd_last = (i == 2);
         #1;
         chk("lr_grant_en_wr", {29'd0, rd_grant, ram_enable, ram_write}, 32'd6);
         chk("lr_valid", {31'd0, rd_valid}, (i == 0) ? 32'd0 : 32'd1);
         if (i > 0) chk("lr_data", {16'd0, rd_data}, {16'd0, pre[i-1]});
      end
      tick(); rd_req = 1'b0; rd_last = 1'b0; #1;
      chk("lr_idle", {31'd0, rd_grant}, 32'd0);
      chk("lr_last_valid", {31'd0, rd_valid}, 32'd1);
      chk("lr_last_data", {16'd0, rd_data}, {16'd0, pre[2]});
      tick(); #1;
      chk("lr_valid_clear", {31'd0, rd_valid}, 32'd0);

      // Forced release: write without last while read is pending
      wr_req = 1'b1; rd_req = 1'b1; rd_address = 16'h0012;
      for (int i = 0; i < 4; i++) begin
         tick(); wr_address = 16'h0040 + 16'(i); #1;
         chk("fr_wr_beat", {30'd0, wr_grant, ram_enable}, 32'd3);
      end
      tick(); #1;
      chk("fr_bubble", {30'd0, wr_grant, rd_grant}, 32'd0);
      tick(); wr_req = 1'b0; rd_last = 1'b1; #1;
      chk("fr_rd_grant", {30'd0, wr_grant, rd_grant}, 32'd1);
      tick(); rd_req = 1'b0; rd_last = 1'b0; #1;
      chk("fr_done", {30'd0, rd_grant, rd_valid}, 32'd1);

      // Uncontested write continues well past maxBurst
      wr_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(); wr_address = 16'h0050 + 16'(i); wr_last = (i == 11); #1;
         chk("long_wr_beat", {30'd0, wr_grant, ram_enable}, 32'd3);
      end
      tick(); wr_req = 1'b0; wr_last = 1'b0; #1;
      chk("long_wr_end", {31'd0, wr_grant}, 32'd0);

      // Dropped request after two beats
      wr_req = 1'b1;
      tick(); #1;
      tick(); #1;
      chk("drop_beat2", {30'd0, wr_grant, ram_enable}, 32'd3);
      tick(); wr_req = 1'b0; rd_req = 1'b1; rd_address = 16'h0010; #1;
      chk("drop_no_beat", {30'd0, wr_grant, ram_enable}, 32'd2);
      tick(); #1;
      chk("drop_idle", {30'd0, wr_grant, rd_grant}, 32'd0);
      tick(); #1;
      chk("drop_rd_grant", {30'd0, rd_grant, ram_enable}, 32'd3);

      // Reset in the middle of the read burst
      tick(); rd_address = 16'h0011; #1;
      chk("rr_beat2_valid", {31'd0, rd_valid}, 32'd1);
      tick(); rd_address = 16'h0012; rst = 1'b1; #1;
      chk("rr_beat3_grant", {31'd0, rd_grant}, 32'd1);
      tick(); rst = 1'b0; rd_req = 1'b1; wr_req = 1'b1; wr_last = 1'b1; #1;
      chk("rr_after_rst", {28'd0, rd_grant, wr_grant, ram_enable, rd_valid}, 32'd0);
      chk("rr_rd_data", {16'd0, rd_data}, 32'd0);
      tick(); #1;
      chk("rr_tie_wr_wins", {30'd0, wr_grant, rd_grant}, 32'd2);
      tick(); wr_req = 1'b0; wr_last = 1'b0; rd_req = 1'b0; #1;
      chk("rr_end", {30'd0, wr_grant, rd_grant}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/io_ram_arbiter.md
# io_ram_arbiter

Shares the single-port IO RAM between two requesters: the DMA write path, which stores decompressed rows block by block, and the compute-side read path, which fetches blocks back. Each grant is a burst. The arbiter picks the winner round-robin, holds the grant until the burst ends, and enforces a maximum burst length when the other side is waiting. It sits between the DMA and the RAM instance inside the IO module and drives the RAM's enable, write, address and input_data pins.

## Interface
- blockSize, 16, data width of one RAM word.
- addrWidth, 16, RAM address width.
- maxBurst, 32, beats allowed per grant before a forced release when the other requester is pending; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  DMA requests or continues a write burst.
- wr_address  in  addrWidth  write address for the current beat.
- wr_data  in  blockSize  write data for the current beat.
- wr_last  in  1  marks the final beat of a write burst.
- wr_grant  out  1  write path owns the RAM.
- rd_req  in  1  reader requests or continues a read burst.
- rd_address  in  addrWidth  read address for the current beat.
- rd_last  in  1  marks the final beat of a read burst.
- rd_grant  out  1  read path owns the RAM.
- rd_data  out  blockSize  read data returned for an earlier beat.
- rd_valid  out  1  rd_data is valid this cycle.
- ram_enable  out  1  drives RAM enable.
- ram_write  out  1  drives RAM write.
- ram_address  out  addrWidth  drives RAM address.
- ram_input_data  out  blockSize  drives RAM input_data.
- ram_output_data  in  blockSize  RAM output_data; valid one cycle after a read access.

## Operation
States: IDLE, WR_BURST, RD_BURST. Internal registers:
- last_served: 0 = write was served last, 1 = read was served last.
- beat_cnt: width clog2(maxBurst+1).

IDLE:
- Only wr_req high → WR_BURST.
- Only rd_req high → RD_BURST.
- Both high → grant the side not named by last_served.
- Neither high → stay in IDLE.
- On entering a burst: beat_cnt ← 0, last_served ← the granted side.

In a burst state:
- wr_grant or rd_grant is 1; the two are one-hot or both 0.
- A beat occurs when grant & req.
- ram_enable = grant & req; ram_write = 1 in WR_BURST, 0 in RD_BURST.
- ram_address and ram_input_data are muxed from the granted requester. ram_input_data = 0 in RD_BURST. All RAM outputs are 0 in IDLE.
- beat_cnt increments on each beat and saturates at maxBurst.

Exit to IDLE on the next edge when any of these holds:
- a beat with last = 1;
- req = 0 (a dropped request is treated as a release);
- beat_cnt reaches maxBurst - 1 on a beat while the other requester's req = 1 (forced release).
- With the other side idle, the burst continues past maxBurst.

Direct hand-off: there is none. The arbiter always passes through one IDLE cycle, so there is a one-cycle bubble between grants.

Read return:
- rd_pending ← 1 on each read beat, otherwise 0.
- rd_valid = rd_pending; rd_data = ram_output_data, registered to the cycle it is valid.

## Timing
Reset values: state IDLE, wr_grant 0, rd_grant 0, ram_enable 0, ram_write 0, ram_address 0, ram_input_data 0, rd_valid 0, rd_data 0, beat_cnt 0, last_served 1 (write wins the first tie).

Cycle-level behaviour:
- Grant latency: req first sampled high in IDLE at edge N → grant = 1 during cycle N+1, and the first beat can occur in that cycle.
- Throughput: one beat per cycle while granted.
- Release: last beat in cycle M → grant = 0 in cycle M+1 (IDLE). The next grant appears in cycle M+2 at the earliest.
- Read latency: read beat in cycle K → rd_valid = 1 with the matching data in cycle K+1. Back-to-back reads give back-to-back rd_valid.
- Req and last both high on the first granted cycle: a one-beat burst.
- rst asserted mid-burst: the burst is abandoned. All outputs take their reset values from the next edge, and no RAM access occurs in the cycle after reset.
- rd_pending is cleared by rst, so no stale rd_valid appears after reset.

## Test plan
- Lone write: wr_req=1 for 4 beats at addresses 0..3, data 0xA000..0xA003, wr_last on beat 4 → wr_grant 1 one cycle after the request; ram_enable=1 and ram_write=1 for exactly 4 cycles with matching address and data; IDLE afterwards.
- Lone read: rd_req for 3 beats at addresses 0..2, with the RAM model preloaded → rd_valid pulses in cycles K+1..K+3 with the preloaded words; ram_write stays 0.
- Tie after reset: wr_req and rd_req both rise in the same cycle → write is granted first; read is granted 2 cycles after the write's last beat. Second tie → read wins.
- Forced release: maxBurst=4, write holds wr_req with no last while rd_req=1 → exactly 4 write beats, one IDLE cycle, then rd_grant. Repeat with rd_req=0 → the write continues for 10+ beats without release.
- Dropped request: wr_req falls mid-burst after 2 beats → IDLE on the next edge; pending read granted one cycle later.
- Reset mid-read-burst: rst high for 1 cycle during beat 2 → rd_grant, ram_enable and rd_valid are all 0 the following cycle; last_served = 1.
